// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO core: register offsets, control/status bit
// positions, the debounce counter width and the address decoder.
package gpio_pkg;

    localparam int DEB_WIDTH = 16;

    localparam logic [15:0] ADDR_DATA_OUT = 16'h0020;
    localparam logic [15:0] ADDR_DIR      = 16'h0024;
    localparam logic [15:0] ADDR_DATA_IN  = 16'h0028;
    localparam logic [15:0] ADDR_RISE_EN  = 16'h002C;
    localparam logic [15:0] ADDR_FALL_EN  = 16'h0030;
    localparam logic [15:0] ADDR_SET      = 16'h0034;
    localparam logic [15:0] ADDR_CLR      = 16'h0038;
    localparam logic [15:0] ADDR_TGL      = 16'h003C;
    localparam logic [15:0] ADDR_DEBOUNCE = 16'h0040;

    localparam int CTRL_OE_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_EVENT_BIT  = 0;
    localparam int STAT_DEB_BIT    = 1;

    typedef enum logic [3:0] {
        REG_NONE,
        REG_DATA_OUT,
        REG_DIR,
        REG_DATA_IN,
        REG_RISE_EN,
        REG_FALL_EN,
        REG_SET,
        REG_CLR,
        REG_TGL,
        REG_DEBOUNCE
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [15:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_DATA_OUT: sel = REG_DATA_OUT;
            ADDR_DIR:      sel = REG_DIR;
            ADDR_DATA_IN:  sel = REG_DATA_IN;
            ADDR_RISE_EN:  sel = REG_RISE_EN;
            ADDR_FALL_EN:  sel = REG_FALL_EN;
            ADDR_SET:      sel = REG_SET;
            ADDR_CLR:      sel = REG_CLR;
            ADDR_TGL:      sel = REG_TGL;
            ADDR_DEBOUNCE: sel = REG_DEBOUNCE;
            default:       sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_if.sv
// Register-access port between the upstream Wishbone subordinate and the GPIO core.
interface gpio_if;

    logic [15:0] i_ip_address;
    logic [31:0] i_ip_wdata;
    logic [31:0] o_ip_rdata;
    logic        i_ip_read_en;
    logic        i_ip_write_en;
    logic        o_ip_ack;
    logic        o_ip_stall;

    modport master (
        output i_ip_address, i_ip_wdata, i_ip_read_en, i_ip_write_en,
        input  o_ip_rdata, o_ip_ack, o_ip_stall
    );

    modport slave (
        input  i_ip_address, i_ip_wdata, i_ip_read_en, i_ip_write_en,
        output o_ip_rdata, o_ip_ack, o_ip_stall
    );

endinterface

// File: rtl/gpio_sync.sv
// Multi-bit flop-chain synchronizer for the asynchronous pin inputs.
module gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_core.sv
// GPIO core: memory-mapped pin registers, optional debounce filter on the
// synchronized inputs, and per-pin rise/fall event pulses.
module gpio_core
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_wb_clk,
    input  logic                  i_wb_rst,
    gpio_if.slave                 ip,
    input  logic [31:0]           i_ip_control,
    output logic [31:0]           o_ip_status,
    output logic [31:0]           o_ip_irq,
    input  logic [GPIO_WIDTH-1:0] i_gpio,
    output logic [GPIO_WIDTH-1:0] o_gpio,
    output logic [GPIO_WIDTH-1:0] o_gpio_oe
);

    logic [GPIO_WIDTH-1:0] data_out_q, data_out_d;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d;
    logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [DEB_WIDTH-1:0]  debounce_q, debounce_d;
    logic [DEB_WIDTH-1:0]  presc_q, presc_d;
    logic [GPIO_WIDTH-1:0] cand_q, cand_d;
    logic [GPIO_WIDTH-1:0] in_q, in_d;
    logic [GPIO_WIDTH-1:0] in_prev_q;
    logic [GPIO_WIDTH-1:0] sync_s;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] edge_hits;
    logic                  deb_write;
    logic                  tick;
    reg_sel_e              sel;
    logic                  unused_ok;

    gpio_sync #(
        .WIDTH  (GPIO_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (i_wb_clk),
        .rst_i (i_wb_rst),
        .d_i   (i_gpio),
        .q_o   (sync_s)
    );

    assign sel       = decode_addr(ip.i_ip_address);
    assign wdata     = ip.i_ip_wdata[GPIO_WIDTH-1:0];
    assign deb_write = ip.i_ip_write_en && (sel == REG_DEBOUNCE);
    assign tick      = (debounce_q != '0) && (presc_q == debounce_q - 16'd1);
    assign unused_ok = ^{ip.i_ip_wdata, i_ip_control};

    assign ip.o_ip_ack   = ip.i_ip_read_en | ip.i_ip_write_en;
    assign ip.o_ip_stall = 1'b0;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        debounce_d = debounce_q;
        presc_d    = presc_q;
        cand_d     = cand_q;
        in_d       = in_q;

        if (ip.i_ip_write_en) begin
            case (sel)
                REG_DATA_OUT: data_out_d = wdata;
                REG_DIR:      dir_d      = wdata;
                REG_RISE_EN:  rise_en_d  = wdata;
                REG_FALL_EN:  fall_en_d  = wdata;
                REG_SET:      data_out_d = data_out_q | wdata;
                REG_CLR:      data_out_d = data_out_q & ~wdata;
                REG_TGL:      data_out_d = data_out_q ^ wdata;
                REG_DEBOUNCE: debounce_d = ip.i_ip_wdata[DEB_WIDTH-1:0];
                default:      ;
            endcase
        end

        // A bit only follows s when two consecutive tick samples agree.
        if (deb_write) begin
            presc_d = '0;
            cand_d  = '0;
        end else if (debounce_q == '0) begin
            presc_d = '0;
            in_d    = sync_s;
        end else if (tick) begin
            presc_d = '0;
            cand_d  = sync_s;
            in_d    = (sync_s & ~(sync_s ^ cand_q)) | (in_q & (sync_s ^ cand_q));
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            data_out_q <= '0;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            debounce_q <= '0;
            presc_q    <= '0;
            cand_q     <= '0;
            in_q       <= '0;
            in_prev_q  <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            debounce_q <= debounce_d;
            presc_q    <= presc_d;
            cand_q     <= cand_d;
            in_q       <= in_d;
            in_prev_q  <= in_q;
        end
    end

    always_comb begin
        case (sel)
            REG_DATA_OUT: ip.o_ip_rdata = 32'(data_out_q);
            REG_DIR:      ip.o_ip_rdata = 32'(dir_q);
            REG_DATA_IN:  ip.o_ip_rdata = 32'(in_q);
            REG_RISE_EN:  ip.o_ip_rdata = 32'(rise_en_q);
            REG_FALL_EN:  ip.o_ip_rdata = 32'(fall_en_q);
            REG_DEBOUNCE: ip.o_ip_rdata = 32'(debounce_q);
            default:      ip.o_ip_rdata = '0;
        endcase
    end

    assign edge_hits = ((in_q & ~in_prev_q & rise_en_q) | (~in_q & in_prev_q & fall_en_q))
                       & {GPIO_WIDTH{i_ip_control[CTRL_IRQ_EN_BIT]}};

    always_comb begin
        o_ip_status                 = '0;
        o_ip_status[STAT_EVENT_BIT] = |edge_hits;
        o_ip_status[STAT_DEB_BIT]   = (debounce_q != '0);
    end

    assign o_ip_irq  = 32'(edge_hits);
    assign o_gpio    = data_out_q;
    assign o_gpio_oe = dir_q & {GPIO_WIDTH{i_ip_control[CTRL_OE_BIT]}};

endmodule

// File: tb/tb_gpio_core.sv
// Directed self-checking bench for gpio_core, built with a 16-pin instance so
// that register bits above the pin count are exercised too.
module tb_gpio_core;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   control;
    logic [31:0]   status;
    logic [31:0]   irq;
    logic [W-1:0]  pins;
    logic [W-1:0]  gpo;
    logic [W-1:0]  oe;

    int   passCount  = 0;
    int   checkCount = 0;
    logic stallSeen  = 1'b0;

    gpio_if bus();

    gpio_core #(
        .GPIO_WIDTH  (W),
        .SYNC_STAGES (2)
    ) dut (
        .i_wb_clk     (clk),
        .i_wb_rst     (rst),
        .ip           (bus.slave),
        .i_ip_control (control),
        .o_ip_status  (status),
        .o_ip_irq     (irq),
        .i_gpio       (pins),
        .o_gpio       (gpo),
        .o_gpio_oe    (oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_ip_stall !== 1'b0) stallSeen = 1'b1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        bus.i_ip_address  = a;
        bus.i_ip_wdata    = d;
        bus.i_ip_write_en = 1'b1;
        step();
        bus.i_ip_write_en = 1'b0;
        bus.i_ip_wdata    = '0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [31:0] d, output logic ak);
        bus.i_ip_address = a;
        bus.i_ip_read_en = 1'b1;
        #1;
        d  = bus.o_ip_rdata;
        ak = bus.o_ip_ack;
        bus.i_ip_read_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        ak;
        rst     = 1'b1;
        control = 32'h3;
        pins    = '0;
        repeat (3) step();
        rst = 1'b0;
        checkCount++;
        if (gpo !== 16'h0000) $display("[TB] FAIL reset_gpio: got %h want 0000", gpo);
        else passCount++;
        checkCount++;
        if (oe !== 16'h0000) $display("[TB] FAIL reset_oe: got %h want 0000", oe);
        else passCount++;
        checkCount++;
        if (irq !== 32'h0) $display("[TB] FAIL reset_irq: got %h want 0", irq);
        else passCount++;
        checkCount++;
        if (status !== 32'h0) $display("[TB] FAIL reset_status: got %h want 0", status);
        else passCount++;
        checkCount++;
        if (bus.o_ip_ack !== 1'b0) $display("[TB] FAIL idle_ack: got %b want 0", bus.o_ip_ack);
        else passCount++;
        peek(16'h0020, rd, ak);
        checkCount++;
        if (rd !== 32'h0) $display("[TB] FAIL reset_data_out: got %h want 0", rd);
        else passCount++;
        control = 32'h0;
    endtask

    task automatic test_output();
        logic [31:0] rd;
        logic        ak;
        control = 32'h1;
        bus_write(16'h0024, 32'hABCD_00FF);
        bus_write(16'h0020, 32'h0000_00A5);
        checkCount++;
        if (oe !== 16'h00FF) $display("[TB] FAIL oe_enabled: got %h want 00ff", oe);
        else passCount++;
        checkCount++;
        if (gpo !== 16'h00A5) $display("[TB] FAIL gpio_drive: got %h want 00a5", gpo);
        else passCount++;
        peek(16'h0024, rd, ak);
        checkCount++;
        if (rd !== 32'h0000_00FF) $display("[TB] FAIL dir_width_mask: got %h want 000000ff", rd);
        else passCount++;
        control = 32'h0;
        #1;
        checkCount++;
        if (oe !== 16'h0000) $display("[TB] FAIL oe_disabled: got %h want 0000", oe);
        else passCount++;
    endtask

    task automatic test_set_clr_tgl();
        logic [31:0] rd;
        logic        ak;
        logic [15:0] wo [3] = '{16'h0034, 16'h0038, 16'h003C};
        bus_write(16'h0020, 32'h0F);
        bus_write(16'h0034, 32'h30);
        peek(16'h0020, rd, ak);
        checkCount++;
        if (rd !== 32'h3F) $display("[TB] FAIL set: got %h want 3f", rd);
        else passCount++;
        bus_write(16'h0038, 32'h03);
        peek(16'h0020, rd, ak);
        checkCount++;
        if (rd !== 32'h3C) $display("[TB] FAIL clr: got %h want 3c", rd);
        else passCount++;
        bus_write(16'h003C, 32'hFF);
        peek(16'h0020, rd, ak);
        checkCount++;
        if (rd !== 32'hC3) $display("[TB] FAIL tgl: got %h want c3", rd);
        else passCount++;
        checkCount++;
        if (gpo !== 16'h00C3) $display("[TB] FAIL tgl_pin: got %h want 00c3", gpo);
        else passCount++;
        for (int i = 0; i < 3; i++) begin
            peek(wo[i], rd, ak);
            checkCount++;
            if (rd !== 32'h0) $display("[TB] FAIL wo_read_%h: got %h want 0", wo[i], rd);
            else passCount++;
        end
        bus_write(16'h0040, 32'hFFFF_1234);
        peek(16'h0040, rd, ak);
        checkCount++;
        if (rd !== 32'h0000_1234) $display("[TB] FAIL debounce_read: got %h want 00001234", rd);
        else passCount++;
        checkCount++;
        if (status !== 32'h2) $display("[TB] FAIL status_deb_on: got %h want 2", status);
        else passCount++;
        bus_write(16'h0040, 32'h0);
        checkCount++;
        if (status !== 32'h0) $display("[TB] FAIL status_deb_off: got %h want 0", status);
        else passCount++;
    endtask

    task automatic test_edge_irq();
        logic [31:0] rd;
        logic        ak;
        logic        bad;
        bus_write(16'h002C, 32'h1);
        bus_write(16'h0030, 32'h0);
        control = 32'h2;
        pins    = '0;
        repeat (4) step();
        pins[0] = 1'b1;
        step();
        step();
        peek(16'h0028, rd, ak);
        checkCount++;
        if (rd !== 32'h0 || irq !== 32'h0)
            $display("[TB] FAIL rise_early: data_in %h irq %h want 0/0", rd, irq);
        else passCount++;
        step();
        peek(16'h0028, rd, ak);
        checkCount++;
        if (rd !== 32'h1) $display("[TB] FAIL rise_latency: data_in %h want 1", rd);
        else passCount++;
        checkCount++;
        if (irq !== 32'h1 || status !== 32'h1)
            $display("[TB] FAIL rise_pulse: irq %h status %h want 1/1", irq, status);
        else passCount++;
        step();
        checkCount++;
        if (irq !== 32'h0) $display("[TB] FAIL pulse_width: irq %h want 0", irq);
        else passCount++;
        pins[0] = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            step();
            if (irq !== 32'h0) bad = 1'b1;
        end
        checkCount++;
        if (bad !== 1'b0) $display("[TB] FAIL fall_no_pulse: pulse seen %b want 0", bad);
        else passCount++;
        peek(16'h0028, rd, ak);
        checkCount++;
        if (rd !== 32'h0) $display("[TB] FAIL fall_data_in: got %h want 0", rd);
        else passCount++;
    endtask

    task automatic test_debounce();
        logic [31:0] rd;
        logic        ak;
        int          n;
        logic        found;
        bus_write(16'h0040, 32'h4);
        pins[1] = 1'b1;
        repeat (3) step();
        pins[1] = 1'b0;
        repeat (12) step();
        peek(16'h0028, rd, ak);
        checkCount++;
        if (rd !== 32'h0) $display("[TB] FAIL glitch_filtered: data_in %h want 0", rd);
        else passCount++;
        pins[1] = 1'b1;
        found   = 1'b0;
        n       = 0;
        for (int i = 1; i <= 14 && !found; i++) begin
            step();
            peek(16'h0028, rd, ak);
            if (rd[1] === 1'b1) begin
                found = 1'b1;
                n     = i;
            end
        end
        checkCount++;
        if (!found || n < 7 || n > 10)
            $display("[TB] FAIL debounce_level: settled after %0d edges (found %b) want 7..10", n, found);
        else passCount++;
        repeat (4) step();
        pins = '0;
        bus_write(16'h0040, 32'h0);
        repeat (4) step();
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        logic        ak;
        logic        wak;
        peek(16'h0044, rd, ak);
        checkCount++;
        if (rd !== 32'h0 || ak !== 1'b1)
            $display("[TB] FAIL unmapped_read: rdata %h ack %b want 0/1", rd, ak);
        else passCount++;
        bus.i_ip_address  = 16'h0044;
        bus.i_ip_wdata    = 32'hFFFF_FFFF;
        bus.i_ip_write_en = 1'b1;
        #1;
        wak = bus.o_ip_ack;
        step();
        bus.i_ip_write_en = 1'b0;
        checkCount++;
        if (wak !== 1'b1) $display("[TB] FAIL unmapped_write_ack: got %b want 1", wak);
        else passCount++;
        peek(16'h0020, rd, ak);
        checkCount++;
        if (rd !== 32'hC3) $display("[TB] FAIL unmapped_data_out: got %h want c3", rd);
        else passCount++;
        peek(16'h0024, rd, ak);
        checkCount++;
        if (rd !== 32'hFF) $display("[TB] FAIL unmapped_dir: got %h want ff", rd);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        ak;
        logic        sawIrq;
        logic        bad;
        control = 32'h3;
        bus_write(16'h002C, 32'h0);
        bus_write(16'h0030, 32'hFFFF_FFFF);
        sawIrq = 1'b0;
        repeat (6) begin
            pins = ~pins;
            step();
            if (irq !== 32'h0) sawIrq = 1'b1;
        end
        checkCount++;
        if (sawIrq !== 1'b1) $display("[TB] FAIL fall_irq_seen: got %b want 1", sawIrq);
        else passCount++;
        rst               = 1'b1;
        bus.i_ip_address  = 16'h0020;
        bus.i_ip_wdata    = 32'hFFFF;
        bus.i_ip_write_en = 1'b1;
        pins = ~pins;
        step();
        bus.i_ip_write_en = 1'b0;
        checkCount++;
        if (gpo !== 16'h0 || oe !== 16'h0 || irq !== 32'h0 || status !== 32'h0)
            $display("[TB] FAIL reset_mid_outputs: gpio %h oe %h irq %h status %h want all 0",
                     gpo, oe, irq, status);
        else passCount++;
        repeat (2) begin
            pins = ~pins;
            step();
        end
        pins = '0;
        step();
        rst = 1'b0;
        peek(16'h0020, rd, ak);
        checkCount++;
        if (rd !== 32'h0) $display("[TB] FAIL reset_beats_write: data_out %h want 0", rd);
        else passCount++;
        bus_write(16'h0030, 32'hFFFF_FFFF);
        bad = 1'b0;
        repeat (6) begin
            step();
            if (irq !== 32'h0) bad = 1'b1;
        end
        checkCount++;
        if (bad !== 1'b0) $display("[TB] FAIL post_reset_no_irq: pulse seen %b want 0", bad);
        else passCount++;
    endtask

    initial begin
        bus.i_ip_address  = '0;
        bus.i_ip_wdata    = '0;
        bus.i_ip_read_en  = 1'b0;
        bus.i_ip_write_en = 1'b0;
        rst     = 1'b1;
        control = '0;
        pins    = '0;
        #1;
        test_reset();
        test_output();
        test_set_clr_tgl();
        test_edge_irq();
        test_debounce();
        test_unmapped();
        test_reset_mid();
        checkCount++;
        if (stallSeen !== 1'b0) $display("[TB] FAIL stall_const: stall seen %b want 0", stallSeen);
        else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/gpio_core.md
GPIO_CORE -- requirements
Module: gpio_core

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 32, number of pins (1..32); bits at or above GPIO_WIDTH SHALL read 0 and ignore writes.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (at least 2).
REQ-003 i_wb_clk  input  1  sole clock; one clock domain; every flop on the rising edge.
REQ-004 i_wb_rst  input  1  reset; synchronous, active-high.
REQ-005 i_ip_address  input  16  byte address of the IP register, from the upstream Wishbone subordinate interface.
REQ-006 i_ip_wdata  input  32  write data, already byte-merged upstream.
REQ-007 o_ip_rdata  output  32  combinational read data of the addressed register.
REQ-008 i_ip_read_en / i_ip_write_en  input  1 each  access strobes; never both high.
REQ-009 o_ip_ack  output  1  access acknowledge.
REQ-010 o_ip_stall  output  1  access stall.
REQ-011 i_ip_control  input  32  control word; bit0 = output enable, bit1 = irq enable.
REQ-012 o_ip_status  output  32  status word; bit0 = any edge event this cycle, bit1 = debounce active; other bits 0.
REQ-013 o_ip_irq  output  32  per-pin single-cycle edge-event pulses.
REQ-014 i_gpio  input  GPIO_WIDTH  asynchronous pin inputs.
REQ-015 o_gpio / o_gpio_oe  output  GPIO_WIDTH each  pin drive value and per-pin output enable.

Function
REQ-016 Register map (byte offsets), all 32-bit:
- 0x20 DATA_OUT, RW.
- 0x24 DIR, RW; 1 = output.
- 0x28 DATA_IN, RO; filtered input.
- 0x2C RISE_EN, RW.
- 0x30 FALL_EN, RW.
- 0x34 SET, write-1-sets DATA_OUT; reads 0.
- 0x38 CLR, write-1-clears DATA_OUT; reads 0.
- 0x3C TGL, write-1-toggles DATA_OUT; reads 0.
- 0x40 DEBOUNCE, RW, low 16 bits; upper bits read 0.
REQ-017 Unmapped address: reads SHALL return 0, writes SHALL be ignored, and the access SHALL still be acknowledged.
REQ-018 o_ip_ack SHALL equal (i_ip_read_en | i_ip_write_en), combinationally, in the same cycle; zero wait states.
REQ-019 o_ip_stall SHALL be constant 0.
REQ-020 o_ip_rdata SHALL decode i_ip_address whenever the address is valid, including during write cycles, because upstream uses it for the byte-merge.
REQ-021 A register write SHALL take effect on the clock edge ending the i_ip_write_en cycle.
REQ-022 o_gpio SHALL equal DATA_OUT, registered.
REQ-023 o_gpio_oe SHALL equal DIR & {GPIO_WIDTH{i_ip_control[0]}}, combinational.
REQ-024 Input path: i_gpio passes through SYNC_STAGES flops to give signal s, then the filter stage to give in_q (DATA_IN).
REQ-025 With DEBOUNCE == 0, in_q SHALL be updated from s every cycle; total pin-to-DATA_IN latency = SYNC_STAGES+1 edges.
REQ-026 With DEBOUNCE == N > 0:
- A 16-bit prescaler counts 0..N-1 and asserts tick at N-1, then wraps to 0.
- On tick, cand <= s.
- On tick, per bit, in_q[i] <= s[i] only if s[i] == cand[i]; otherwise in_q[i] holds (two consecutive equal samples required).
REQ-027 A write to DEBOUNCE SHALL clear the prescaler and cand; in_q SHALL hold its value.
REQ-028 in_prev SHALL register in_q every cycle.
REQ-029 o_ip_irq SHALL be combinational: ((in_q & ~in_prev & RISE_EN) | (~in_q & in_prev & FALL_EN)), gated by i_ip_control[1], zero above GPIO_WIDTH; each edge gives exactly one 1-cycle pulse.
REQ-030 o_ip_status[0] SHALL equal the OR of o_ip_irq; o_ip_status[1] SHALL equal (DEBOUNCE != 0).

Reset
REQ-031 On i_wb_rst, all registers, the synchronizer, in_q, in_prev, cand and the prescaler SHALL clear to 0 on the next edge.
REQ-032 Consequently o_gpio = 0, o_gpio_oe = 0 and o_ip_irq = 0 from the first cycle after reset.
REQ-033 Reset SHALL win over a simultaneous write; reset in mid-debounce SHALL discard the pending candidate.

Structure
REQ-034 Package gpio_pkg SHALL hold the register offset constants, the control/status bit-index constants and the DEBOUNCE width.
REQ-035 Sub-module gpio_sync SHALL be a parameterized SYNC_STAGES multi-bit synchronizer with reset; all other logic SHALL be in gpio_core.

Verification
REQ-036 Write DIR=0x0000_00FF, DATA_OUT=0x0000_00A5 with control=1 -> o_gpio_oe=0x0000_00FF and o_gpio=0x0000_00A5; with control=0 -> o_gpio_oe=0.
REQ-037 From DATA_OUT=0x0F: write SET=0x30 -> 0x3F; then CLR=0x03 -> 0x3C; then TGL=0xFF -> 0xC3; SET/CLR/TGL reads return 0.
REQ-038 DEBOUNCE=0, RISE_EN=0x1, control=0x2; i_gpio[0] rises before edge k -> DATA_IN[0]=1 after edge k+2; o_ip_irq=0x1 for exactly one cycle; a fall produces no pulse.
REQ-039 DEBOUNCE=4; a 3-cycle glitch on i_gpio[1] -> DATA_IN unchanged; a level held for 10 cycles -> DATA_IN[1] updates within 8 cycles of s changing.
REQ-040 Read 0x44 -> rdata=0 with ack in the same cycle; write 0x44 -> no register changes; o_ip_stall stays 0 throughout.
REQ-041 Assert reset while FALL_EN=0xFFFF_FFFF and pins toggling -> all outputs 0 the next cycle; no irq pulse after release until a new edge.
